// File: rtl/dmem_arbiter_if.sv
// Signal bundle between the two requesters, the arbiter and the data memory.
// The slave view belongs to the arbiter. The master view belongs to the requesters and the memory.
interface dmem_arbiter_if #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
);
  logic                  p0_req;
  logic                  p0_we;
  logic [DM_ADDRESS-1:0] p0_addr;
  logic [DATA_W-1:0]     p0_wdata;
  logic [2:0]            p0_funct3;
  logic                  p0_gnt;
  logic                  p0_rvalid;
  logic [DATA_W-1:0]     p0_rdata;

  logic                  p1_req;
  logic                  p1_we;
  logic [DM_ADDRESS-1:0] p1_addr;
  logic [DATA_W-1:0]     p1_wdata;
  logic [2:0]            p1_funct3;
  logic                  p1_lock;
  logic                  p1_gnt;
  logic                  p1_rvalid;
  logic [DATA_W-1:0]     p1_rdata;

  logic                  dm_MemRead;
  logic                  dm_MemWrite;
  logic [DM_ADDRESS-1:0] dm_a;
  logic [DATA_W-1:0]     dm_wd;
  logic [2:0]            dm_Funct3;
  logic [DATA_W-1:0]     dm_rd;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata, p0_funct3,
    input  p1_req, p1_we, p1_addr, p1_wdata, p1_funct3, p1_lock,
    input  dm_rd,
    output p0_gnt, p0_rvalid, p0_rdata,
    output p1_gnt, p1_rvalid, p1_rdata,
    output dm_MemRead, dm_MemWrite, dm_a, dm_wd, dm_Funct3
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata, p0_funct3,
    output p1_req, p1_we, p1_addr, p1_wdata, p1_funct3, p1_lock,
    output dm_rd,
    input  p0_gnt, p0_rvalid, p0_rdata,
    input  p1_gnt, p1_rvalid, p1_rdata,
    input  dm_MemRead, dm_MemWrite, dm_a, dm_wd, dm_Funct3
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter. Port 0 (MEM stage) has fixed priority.
// Port 1 (debug/loader) has a starvation guard and a lock mode for atomic sequences.
module dmem_arbiter #(
  parameter int DM_ADDRESS   = 9,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input logic           clk,
  input logic           reset,
  dmem_arbiter_if.slave bus
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT_C = CW'(STARVE_LIMIT);

  typedef enum logic [0:0] {ARB = 1'b0, LOCK1 = 1'b1} state_t;

  state_t                state_r;
  state_t                state_s;
  logic [CW-1:0]         wait_cnt_r;
  logic                  p0_gnt_s;
  logic                  p1_gnt_s;
  logic                  dm_read_s;
  logic                  dm_write_s;
  logic [DM_ADDRESS-1:0] dm_a_s;
  logic [DATA_W-1:0]     dm_wd_s;
  logic [2:0]            dm_funct3_s;
  logic                  p0_rvalid_r;
  logic                  p1_rvalid_r;
  logic [DATA_W-1:0]     p0_rdata_r;
  logic [DATA_W-1:0]     p1_rdata_r;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ARB;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic. Lock is entered only on an actual port-1 grant and is held while p1_lock stays high.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ARB: begin
        if (p1_gnt_s && bus.p1_lock) state_s = LOCK1;
        else                         state_s = ARB;
      end
      LOCK1: begin
        if (!bus.p1_lock) state_s = ARB;
        else              state_s = LOCK1;
      end
      default: state_s = ARB;
    endcase
  end

  // Grant outputs. In LOCK1 port 0 is stalled even when port 1 leaves the memory idle.
  always_comb begin
    p0_gnt_s = 1'b0;
    p1_gnt_s = 1'b0;
    case (state_r)
      ARB: begin
        if (bus.p1_req && (!bus.p0_req || (wait_cnt_r == LIMIT_C))) begin
          p1_gnt_s = 1'b1;
        end else if (bus.p0_req) begin
          p0_gnt_s = 1'b1;
        end else begin
          p0_gnt_s = 1'b0;
          p1_gnt_s = 1'b0;
        end
      end
      LOCK1: begin
        p1_gnt_s = bus.p1_req;
      end
      default: begin
        p0_gnt_s = 1'b0;
        p1_gnt_s = 1'b0;
      end
    endcase
  end

  // Memory-side mux from the winning port; all-zero when idle
  always_comb begin
    dm_read_s   = 1'b0;
    dm_write_s  = 1'b0;
    dm_a_s      = '0;
    dm_wd_s     = '0;
    dm_funct3_s = 3'd0;
    if (p1_gnt_s) begin
      dm_read_s   = ~bus.p1_we;
      dm_write_s  = bus.p1_we;
      dm_a_s      = bus.p1_addr;
      dm_wd_s     = bus.p1_wdata;
      dm_funct3_s = bus.p1_funct3;
    end else if (p0_gnt_s) begin
      dm_read_s   = ~bus.p0_we;
      dm_write_s  = bus.p0_we;
      dm_a_s      = bus.p0_addr;
      dm_wd_s     = bus.p0_wdata;
      dm_funct3_s = bus.p0_funct3;
    end else begin
      dm_read_s   = 1'b0;
      dm_write_s  = 1'b0;
    end
  end

  // Starvation counter: counts denied port-1 request cycles and saturates at the limit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt_r <= '0;
    end else if (!bus.p1_req || p1_gnt_s) begin
      wait_cnt_r <= '0;
    end else if (wait_cnt_r != LIMIT_C) begin
      wait_cnt_r <= wait_cnt_r + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  // Load responses: capture dm_rd at the end of the grant cycle and pulse rvalid for one cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p0_rvalid_r <= 1'b0;
      p1_rvalid_r <= 1'b0;
      p0_rdata_r  <= '0;
      p1_rdata_r  <= '0;
    end else begin
      p0_rvalid_r <= p0_gnt_s & ~bus.p0_we;
      p1_rvalid_r <= p1_gnt_s & ~bus.p1_we;
      if (p0_gnt_s && !bus.p0_we) p0_rdata_r <= bus.dm_rd;
      else                        p0_rdata_r <= p0_rdata_r;
      if (p1_gnt_s && !bus.p1_we) p1_rdata_r <= bus.dm_rd;
      else                        p1_rdata_r <= p1_rdata_r;
    end
  end

  assign bus.p0_gnt      = p0_gnt_s;
  assign bus.p1_gnt      = p1_gnt_s;
  assign bus.p0_rvalid   = p0_rvalid_r;
  assign bus.p1_rvalid   = p1_rvalid_r;
  assign bus.p0_rdata    = p0_rdata_r;
  assign bus.p1_rdata    = p1_rdata_r;
  assign bus.dm_MemRead  = dm_read_s;
  assign bus.dm_MemWrite = dm_write_s;
  assign bus.dm_a        = dm_a_s;
  assign bus.dm_wd       = dm_wd_s;
  assign bus.dm_Funct3   = dm_funct3_s;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios followed by randomized traffic.
// Results are compared against a transaction-level reference model.
module tb_dmem_arbiter;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.DM_ADDRESS(9), .DATA_W(32)) bus ();

  dmem_arbiter #(.DM_ADDRESS(9), .DATA_W(32), .STARVE_LIMIT(LIMIT)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Physical data memory with a backdoor for preload and clear
  logic [31:0] mem [0:511];
  logic        bd_clr;
  logic        bd_we;
  logic [8:0]  bd_addr;
  logic [31:0] bd_data;

  always @(posedge clk) begin
    if (bd_clr) begin
      for (int i = 0; i < 512; i++) mem[i] <= 32'h0;
    end else if (bd_we) begin
      mem[bd_addr] <= bd_data;
    end else if (bus.dm_MemWrite) begin
      mem[bus.dm_a] <= bus.dm_wd;
    end
  end

  assign bus.dm_rd = mem[bus.dm_a];

  // Reference model state
  logic [31:0] ref_mem [0:511];
  int          m_wait;
  bit          m_locked;
  bit          e_rv0, e_rv1;
  logic [31:0] e_rd0, e_rd1;
  int          n_checks = 0;
  int          n_fail   = 0;

  // Return the port that should own memory now: 0 = none, 1 = port 0, 2 = port 1
  function automatic int exp_grant();
    if (m_locked) return bus.p1_req ? 2 : 0;
    if (bus.p1_req && (!bus.p0_req || m_wait >= LIMIT)) return 2;
    if (bus.p0_req) return 1;
    return 0;
  endfunction

  task automatic model_reset();
    e_rv0 = 1'b0; e_rv1 = 1'b0; e_rd0 = 32'h0; e_rd1 = 32'h0;
    m_wait = 0; m_locked = 1'b0;
  endtask

  // Step the model over one clock edge using the current inputs, then move to the next negedge
  task automatic advance();
    int g;
    g = exp_grant();
    e_rv0 = 1'b0;
    e_rv1 = 1'b0;
    if (g == 1) begin
      if (!bus.p0_we) begin e_rv0 = 1'b1; e_rd0 = ref_mem[bus.p0_addr]; end
      else ref_mem[bus.p0_addr] = bus.p0_wdata;
    end else if (g == 2) begin
      if (!bus.p1_we) begin e_rv1 = 1'b1; e_rd1 = ref_mem[bus.p1_addr]; end
      else ref_mem[bus.p1_addr] = bus.p1_wdata;
    end
    if (bus.p1_req && g != 2) m_wait++;
    else m_wait = 0;
    m_locked = m_locked ? bus.p1_lock : (g == 2 && bus.p1_lock);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_idle();
    bus.p0_req = 1'b0; bus.p0_we = 1'b0; bus.p0_addr = 9'h0; bus.p0_wdata = 32'h0; bus.p0_funct3 = 3'd0;
    bus.p1_req = 1'b0; bus.p1_we = 1'b0; bus.p1_addr = 9'h0; bus.p1_wdata = 32'h0; bus.p1_funct3 = 3'd0;
    bus.p1_lock = 1'b0;
  endtask

  task automatic test_reset();
    set_idle();
    #1;
    n_checks++; if (bus.p0_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_p0_rvalid got %b exp 0", bus.p0_rvalid); end
    n_checks++; if (bus.p1_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_p1_rvalid got %b exp 0", bus.p1_rvalid); end
    n_checks++; if (bus.p0_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_p0_rdata got %h exp 0", bus.p0_rdata); end
    n_checks++; if (bus.p1_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_p1_rdata got %h exp 0", bus.p1_rdata); end
    n_checks++; if ({bus.p0_gnt, bus.p1_gnt, bus.dm_MemRead, bus.dm_MemWrite} !== 4'b0) begin
      n_fail++; $display("FAIL reset_idle_bus got %b exp 0000", {bus.p0_gnt, bus.p1_gnt, bus.dm_MemRead, bus.dm_MemWrite}); end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    advance();
  endtask

  task automatic test_p0_load();
    bd_we = 1'b1; bd_addr = 9'h010; bd_data = 32'hDEADBEEF;
    ref_mem[9'h010] = 32'hDEADBEEF;
    advance();
    bd_we = 1'b0;
    bus.p0_req = 1'b1; bus.p0_we = 1'b0; bus.p0_addr = 9'h010; bus.p0_funct3 = 3'd2;
    #1;
    n_checks++; if (bus.p0_gnt !== 1'b1) begin n_fail++; $display("FAIL load_p0_gnt got %b exp 1", bus.p0_gnt); end
    n_checks++; if (bus.dm_MemRead !== 1'b1 || bus.dm_MemWrite !== 1'b0) begin
      n_fail++; $display("FAIL load_dm_ctl got rd=%b wr=%b exp rd=1 wr=0", bus.dm_MemRead, bus.dm_MemWrite); end
    n_checks++; if (bus.dm_a !== 9'h010 || bus.dm_Funct3 !== 3'd2) begin
      n_fail++; $display("FAIL load_dm_addr got a=%h f3=%0d exp a=010 f3=2", bus.dm_a, bus.dm_Funct3); end
    advance();
    set_idle();
    #1;
    n_checks++; if (bus.p0_rvalid !== 1'b1) begin n_fail++; $display("FAIL load_p0_rvalid got %b exp 1", bus.p0_rvalid); end
    n_checks++; if (bus.p0_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL load_p0_rdata got %h exp deadbeef", bus.p0_rdata); end
    advance();
    #1;
    n_checks++; if (bus.p0_rvalid !== 1'b0) begin n_fail++; $display("FAIL load_rvalid_pulse got %b exp 0", bus.p0_rvalid); end
    n_checks++; if (bus.p0_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL load_rdata_hold got %h exp deadbeef", bus.p0_rdata); end
  endtask

  task automatic test_store_load();
    bus.p1_req = 1'b1; bus.p1_we = 1'b1; bus.p1_addr = 9'h020; bus.p1_wdata = 32'h12345678; bus.p1_funct3 = 3'd2;
    #1;
    n_checks++; if (bus.p1_gnt !== 1'b1 || bus.dm_MemWrite !== 1'b1 || bus.dm_MemRead !== 1'b0) begin
      n_fail++; $display("FAIL st_p1_grant got gnt=%b wr=%b rd=%b exp 1 1 0", bus.p1_gnt, bus.dm_MemWrite, bus.dm_MemRead); end
    n_checks++; if (bus.dm_wd !== 32'h12345678 || bus.dm_a !== 9'h020 || bus.dm_Funct3 !== 3'd2) begin
      n_fail++; $display("FAIL st_dm_fields got wd=%h a=%h f3=%0d exp 12345678 020 2", bus.dm_wd, bus.dm_a, bus.dm_Funct3); end
    advance();
    set_idle();
    bus.p0_req = 1'b1; bus.p0_addr = 9'h020; bus.p0_funct3 = 3'd2;
    #1;
    n_checks++; if (bus.p1_rvalid !== 1'b0) begin n_fail++; $display("FAIL st_no_rvalid got %b exp 0", bus.p1_rvalid); end
    n_checks++; if (bus.p0_gnt !== 1'b1) begin n_fail++; $display("FAIL st_p0_gnt got %b exp 1", bus.p0_gnt); end
    advance();
    set_idle();
    #1;
    n_checks++; if (bus.p0_rvalid !== 1'b1 || bus.p0_rdata !== 32'h12345678) begin
      n_fail++; $display("FAIL st_readback got v=%b d=%h exp v=1 d=12345678", bus.p0_rvalid, bus.p0_rdata); end
    n_checks++; if (bus.p1_rvalid !== 1'b0) begin n_fail++; $display("FAIL st_no_rvalid2 got %b exp 0", bus.p1_rvalid); end
    advance();
  endtask

  task automatic test_starvation();
    bit exp_p1;
    bus.p0_req = 1'b1; bus.p0_we = 1'b0; bus.p0_addr = 9'h010; bus.p0_funct3 = 3'd2;
    bus.p1_req = 1'b1; bus.p1_we = 1'b0; bus.p1_addr = 9'h020; bus.p1_funct3 = 3'd2;
    for (int i = 0; i < 15; i++) begin
      exp_p1 = ((i % 5) == 4);
      #1;
      n_checks++; if (bus.p1_gnt !== exp_p1 || bus.p0_gnt !== !exp_p1) begin
        n_fail++; $display("FAIL starve_cycle%0d got p0=%b p1=%b exp p0=%b p1=%b", i, bus.p0_gnt, bus.p1_gnt, !exp_p1, exp_p1); end
      n_checks++; if (bus.p1_rvalid !== ((i % 5) == 0 && i > 0)) begin
        n_fail++; $display("FAIL starve_rvalid%0d got %b exp %b", i, bus.p1_rvalid, ((i % 5) == 0 && i > 0)); end
      advance();
    end
    set_idle();
    advance();
  endtask

  task automatic test_lock();
    bit exp_p0, exp_p1;
    for (int i = 0; i < 6; i++) begin
      bus.p0_req = (i >= 1); bus.p0_we = 1'b0; bus.p0_addr = 9'h010;
      bus.p1_req = (i < 3); bus.p1_we = 1'b1; bus.p1_lock = (i < 4);
      bus.p1_addr = 9'(9'h030 + i); bus.p1_wdata = 32'hA5A50000 + i;
      exp_p1 = (i < 3);
      exp_p0 = (i == 5);
      #1;
      n_checks++; if (bus.p0_gnt !== exp_p0 || bus.p1_gnt !== exp_p1) begin
        n_fail++; $display("FAIL lock_cycle%0d got p0=%b p1=%b exp p0=%b p1=%b", i, bus.p0_gnt, bus.p1_gnt, exp_p0, exp_p1); end
      n_checks++; if (bus.dm_MemWrite !== exp_p1 || bus.p1_rvalid !== 1'b0) begin
        n_fail++; $display("FAIL lock_mem%0d got wr=%b rv=%b exp wr=%b rv=0", i, bus.dm_MemWrite, bus.p1_rvalid, exp_p1); end
      advance();
    end
    set_idle();
    advance();
  endtask

  task automatic test_idle();
    set_idle();
    for (int i = 0; i < 10; i++) begin
      #1;
      n_checks++; if ({bus.dm_MemRead, bus.dm_MemWrite, bus.p0_rvalid, bus.p1_rvalid} !== 4'b0 || bus.dm_a !== 9'h0) begin
        n_fail++; $display("FAIL idle%0d got rd=%b wr=%b rv0=%b rv1=%b a=%h exp all 0", i,
          bus.dm_MemRead, bus.dm_MemWrite, bus.p0_rvalid, bus.p1_rvalid, bus.dm_a); end
      advance();
    end
  endtask

  task automatic test_reset_lock();
    set_idle();
    bus.p1_req = 1'b1; bus.p1_we = 1'b0; bus.p1_addr = 9'h010; bus.p1_lock = 1'b1;
    #1;
    n_checks++; if (bus.p1_gnt !== 1'b1) begin n_fail++; $display("FAIL rstlk_p1_gnt got %b exp 1", bus.p1_gnt); end
    advance();
    bus.p1_req = 1'b0;
    bus.p0_req = 1'b1; bus.p0_we = 1'b0; bus.p0_addr = 9'h020;
    #1;
    n_checks++; if (bus.p1_rvalid !== 1'b1 || bus.p1_rdata !== e_rd1) begin
      n_fail++; $display("FAIL rstlk_pending got v=%b d=%h exp v=1 d=%h", bus.p1_rvalid, bus.p1_rdata, e_rd1); end
    n_checks++; if (bus.p0_gnt !== 1'b0) begin n_fail++; $display("FAIL rstlk_p0_stalled got %b exp 0", bus.p0_gnt); end
    reset = 1'b1;
    #1;
    n_checks++; if (bus.p1_rvalid !== 1'b0 || bus.p1_rdata !== 32'h0 || bus.p0_rdata !== 32'h0) begin
      n_fail++; $display("FAIL rstlk_cleared got v1=%b d1=%h d0=%h exp 0", bus.p1_rvalid, bus.p1_rdata, bus.p0_rdata); end
    bus.p1_lock = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    #1;
    n_checks++; if (bus.p0_gnt !== 1'b1 || bus.p1_gnt !== 1'b0) begin
      n_fail++; $display("FAIL rstlk_p0_first got p0=%b p1=%b exp p0=1 p1=0", bus.p0_gnt, bus.p1_gnt); end
    advance();
    set_idle();
    advance();
  endtask

  task automatic test_random();
    int g;
    bit eg0, eg1, erd, ewr;
    logic [8:0]  ea;
    logic [31:0] ewd;
    logic [2:0]  ef3;
    for (int i = 0; i < 400; i++) begin
      bus.p0_req = ($urandom_range(0, 3) != 0); bus.p0_we = $urandom_range(0, 1) == 1;
      bus.p0_addr = 9'($urandom_range(0, 31)); bus.p0_wdata = $urandom; bus.p0_funct3 = 3'($urandom_range(0, 7));
      bus.p1_req = ($urandom_range(0, 1) == 1); bus.p1_we = $urandom_range(0, 1) == 1;
      bus.p1_addr = 9'($urandom_range(0, 31)); bus.p1_wdata = $urandom; bus.p1_funct3 = 3'($urandom_range(0, 7));
      bus.p1_lock = ($urandom_range(0, 2) == 0);
      g = exp_grant();
      eg0 = (g == 1); eg1 = (g == 2);
      erd = 1'b0; ewr = 1'b0; ea = 9'h0; ewd = 32'h0; ef3 = 3'd0;
      if (eg0) begin erd = !bus.p0_we; ewr = bus.p0_we; ea = bus.p0_addr; ewd = bus.p0_wdata; ef3 = bus.p0_funct3; end
      if (eg1) begin erd = !bus.p1_we; ewr = bus.p1_we; ea = bus.p1_addr; ewd = bus.p1_wdata; ef3 = bus.p1_funct3; end
      #1;
      n_checks++; if (bus.p0_gnt !== eg0 || bus.p1_gnt !== eg1) begin
        n_fail++; $display("FAIL rnd_gnt%0d got p0=%b p1=%b exp p0=%b p1=%b", i, bus.p0_gnt, bus.p1_gnt, eg0, eg1); end
      n_checks++; if ({bus.dm_MemRead, bus.dm_MemWrite, bus.dm_a, bus.dm_wd, bus.dm_Funct3} !== {erd, ewr, ea, ewd, ef3}) begin
        n_fail++; $display("FAIL rnd_dm%0d got rd=%b wr=%b a=%h wd=%h f3=%0d exp rd=%b wr=%b a=%h wd=%h f3=%0d", i,
          bus.dm_MemRead, bus.dm_MemWrite, bus.dm_a, bus.dm_wd, bus.dm_Funct3, erd, ewr, ea, ewd, ef3); end
      n_checks++; if (bus.p0_rvalid !== e_rv0 || bus.p0_rdata !== e_rd0) begin
        n_fail++; $display("FAIL rnd_p0_resp%0d got v=%b d=%h exp v=%b d=%h", i, bus.p0_rvalid, bus.p0_rdata, e_rv0, e_rd0); end
      n_checks++; if (bus.p1_rvalid !== e_rv1 || bus.p1_rdata !== e_rd1) begin
        n_fail++; $display("FAIL rnd_p1_resp%0d got v=%b d=%h exp v=%b d=%h", i, bus.p1_rvalid, bus.p1_rdata, e_rv1, e_rd1); end
      n_checks++; if (m_wait > LIMIT + 1) begin
        n_fail++; $display("FAIL rnd_starve%0d got wait=%0d exp <=%0d", i, m_wait, LIMIT + 1); end
      advance();
    end
    set_idle();
    advance();
  endtask

  initial begin
    reset = 1'b1;
    bd_clr = 1'b1; bd_we = 1'b0; bd_addr = 9'h0; bd_data = 32'h0;
    set_idle();
    for (int i = 0; i < 512; i++) ref_mem[i] = 32'h0;
    model_reset();
    repeat (2) @(posedge clk);
    bd_clr = 1'b0;
    @(negedge clk);
    test_reset();
    test_p0_load();
    test_store_load();
    test_starvation();
    test_lock();
    test_idle();
    test_reset_lock();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
